// File: rtl/debug_irq_pkg.sv
// Shared constants and types for the debug interrupt conditioner.
// Debounce is built in only when DEBUG_IRQ_DEBOUNCE_EN is defined.
package debug_irq_pkg;

    typedef logic [1:0] addr_t;

    localparam addr_t ADDR_STATUS  = 2'd0;
    localparam addr_t ADDR_MASK    = 2'd1;
    localparam addr_t ADDR_PENDING = 2'd2;
    localparam addr_t ADDR_CONTROL = 2'd3;

    localparam int CTRL_GEN_BIT = 0;
    localparam int CTRL_POL_LSB = 1;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } db_state_e;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debug_irq_conditioner_if.sv
// Avalon-MM register port of the debug interrupt conditioner.
// Shared by builds with and without DEBUG_IRQ_DEBOUNCE_EN.
interface debug_irq_conditioner_if;
    import debug_irq_pkg::*;

    addr_t       address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/debug_irq_debounce.sv
// Per-source synchronizer followed by an optional debounce filter.
// The filter FSM exists only when DEBUG_IRQ_DEBOUNCE_EN is defined.
module debug_irq_debounce
    import debug_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef DEBUG_IRQ_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic synced_o,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign synced_o = sync_q[SYNC_STAGES-1];

`ifdef DEBUG_IRQ_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    db_state_e state_q;
    logic [CW-1:0] cnt_q;

    // Level only flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            unique case (state_q)
                STABLE: begin
                    if (synced_o != level_q) begin
                        state_q <= CHANGING;
                        cnt_q   <= CW'(1);
                    end
                end
                CHANGING: begin
                    if (synced_o == level_q) begin
                        state_q <= STABLE;
                    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                        level_q <= ~level_q;
                        state_q <= STABLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= synced_o;
        end
    end
`endif

    assign level_o = level_q;

endmodule

// File: rtl/debug_irq_conditioner.sv
// Debug interrupt conditioner: edge capture, CSRs and the PIO request.
// Define DEBUG_IRQ_DEBOUNCE_EN to add the per-source debounce filter.
module debug_irq_conditioner
    import debug_irq_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_SRC-1:0]  irq_src,
    debug_irq_conditioner_if.slave bus,
    output logic                irq_out
);

    if (NUM_SRC < 1 || NUM_SRC > 32 || SYNC_STAGES < 2 ||
        DEBOUNCE_CYCLES < 1) begin : g_cfg_chk
        $error("debug_irq_conditioner: parameter out of range");
    end

    localparam int WW = $clog2(SYNC_STAGES + 1);

    logic [NUM_SRC-1:0] synced;
    logic [NUM_SRC-1:0] level;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] armed_q;
    logic [NUM_SRC-1:0] armed_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_d;
    logic [NUM_SRC-1:0] pol_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] fall;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] clr;
    logic               gen_q;
    logic               irq_q;
    logic               warm_done;
    logic               wr_mask;
    logic               wr_pend;
    logic               wr_ctrl;
    logic [WW-1:0]      warm_q;
    logic [31:0]        wd_pol;
    logic [31:0]        pol_ext;
    logic [31:0]        rd_d;
    logic [31:0]        rdata_q;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        debug_irq_debounce #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef DEBUG_IRQ_DEBOUNCE_EN
            ,
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .raw_i   (irq_src[gi]),
            .synced_o(synced[gi]),
            .level_o (level[gi])
        );
    end

    assign wr_mask = bus.write && (bus.address == ADDR_MASK);
    assign wr_pend = bus.write && (bus.address == ADDR_PENDING);
    assign wr_ctrl = bus.write && (bus.address == ADDR_CONTROL);

    // A source is armed once its level has caught up with the synced
    // input, so a line held active through reset never reports an edge.
    always_comb begin
        warm_done = (warm_q == WW'(SYNC_STAGES));
        armed_d   = armed_q |
                    ({NUM_SRC{warm_done}} & ~(level ^ synced));
        rise      = level & ~prev_q;
        fall      = ~level & prev_q;
        edge_det  = armed_q & ((rise & ~pol_q) | (fall & pol_q));
        clr       = wr_pend ? bus.writedata[NUM_SRC-1:0] : '0;
        pend_d    = (pend_q & ~clr) | edge_det;
        wd_pol    = bus.writedata >> CTRL_POL_LSB;
    end

    always_comb begin
        pol_ext                = '0;
        pol_ext[NUM_SRC-1:0]   = pol_q;
        rd_d                   = '0;
        unique case (1'b1)
            bus.address == ADDR_STATUS:  rd_d[NUM_SRC-1:0] = level;
            bus.address == ADDR_MASK:    rd_d[NUM_SRC-1:0] = mask_q;
            bus.address == ADDR_PENDING: rd_d[NUM_SRC-1:0] = pend_q;
            bus.address == ADDR_CONTROL: begin
                rd_d               = pol_ext << CTRL_POL_LSB;
                rd_d[CTRL_GEN_BIT] = gen_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_q  <= '0;
            armed_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            pol_q   <= '0;
            gen_q   <= 1'b0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (!warm_done) begin
                warm_q <= warm_q + 1'b1;
            end
            armed_q <= armed_d;
            prev_q  <= level;
            pend_q  <= pend_d;
            if (wr_mask) begin
                mask_q <= bus.writedata[NUM_SRC-1:0];
            end
            if (wr_ctrl) begin
                gen_q <= bus.writedata[CTRL_GEN_BIT];
                pol_q <= wd_pol[NUM_SRC-1:0];
            end
            irq_q   <= gen_q & |(pend_q & mask_q);
            rdata_q <= rd_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq_out      = irq_q;

endmodule

// File: tb/tb_debug_irq_conditioner.sv
// Scoreboard bench for debug_irq_conditioner; follows the
// DEBUG_IRQ_DEBOUNCE_EN setting of the build for latency and glitch tests.
module tb_debug_irq_conditioner;
    import debug_irq_pkg::*;

    localparam int NSRC = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 16;
`ifdef DEBUG_IRQ_DEBOUNCE_EN
    localparam int LAT = SYNC + DEB + 2;
`else
    localparam int LAT = SYNC + 2;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NSRC-1:0] irq_src;
    logic            irq_out;

    debug_irq_conditioner_if bus();

    debug_irq_conditioner #(
        .NUM_SRC(NSRC),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .irq_src(irq_src),
        .bus    (bus),
        .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] rd;
    logic [31:0] e;
    int          cyc;
    int          el;

    task automatic bus_write(input addr_t a, input logic [31:0] d);
        bus.address   = a;
        bus.write     = 1'b1;
        bus.writedata = d;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input addr_t a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges counted after sample edge 0 until irq_out is seen high.
    task automatic measure(output int c);
        c = 0;
        @(posedge clk);
        while (c < 200) begin
            @(posedge clk);
            #1;
            c++;
            if (irq_out) break;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        irq_src = 4'b0001;
        bus.address = ADDR_STATUS;
        bus.write = 1'b0;
        bus.writedata = '0;
        #2 reset_n = 1'b0;
        idle(3);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_irq: got %b want 0", irq_out);
        end
        total++;
        if (bus.readdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_rdata: got %h want 0", bus.readdata);
        end
        reset_n = 1'b1;
        idle(LAT + 8);
        bus_write(ADDR_MASK, 32'h1);
        bus_write(ADDR_CONTROL, 32'h1);
        idle(4);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL held_irq: got %b want 0", irq_out);
        end
        exp_q.push_back(32'h0);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL held_pend: got %h want %h", rd, e);
        end
        exp_q.push_back(32'h1);
        bus_read(ADDR_STATUS, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL held_status: got %h want %h", rd, e);
        end
    endtask

    task automatic test_latency;
        bus_write(ADDR_MASK, 32'hF);
        bus_write(ADDR_CONTROL, 32'h1);
        irq_src[2] = 1'b1;
        lat_q.push_back(LAT);
        measure(cyc);
        el = lat_q.pop_front();
        total++;
        if (cyc !== el) begin
            bad++;
            $display("FAIL rise_lat: got %0d want %0d", cyc, el);
        end
        exp_q.push_back(32'h4);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL rise_pend: got %h want %h", rd, e);
        end
        exp_q.push_back(32'h5);
        bus_read(ADDR_STATUS, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL rise_status: got %h want %h", rd, e);
        end
        bus_write(ADDR_PENDING, 32'h4);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL ack_hold: got %b want 1", irq_out);
        end
        idle(1);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL ack_drop: got %b want 0", irq_out);
        end
    endtask

    task automatic test_polarity;
        bus_write(ADDR_CONTROL, 32'h3);
        idle(3);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL pol_noedge: got %b want 0", irq_out);
        end
        irq_src[0] = 1'b0;
        lat_q.push_back(LAT);
        measure(cyc);
        el = lat_q.pop_front();
        total++;
        if (cyc !== el) begin
            bad++;
            $display("FAIL fall_lat: got %0d want %0d", cyc, el);
        end
        exp_q.push_back(32'h1);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL fall_pend: got %h want %h", rd, e);
        end
        bus_write(ADDR_PENDING, 32'h1);
        idle(1);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL fall_ack: got %b want 0", irq_out);
        end
    endtask

    task automatic test_mask_gate;
        irq_src[1] = 1'b1;
        idle(LAT + 2);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL src1_irq: got %b want 1", irq_out);
        end
        bus_write(ADDR_MASK, 32'hD);
        idle(1);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL mask_drop: got %b want 0", irq_out);
        end
        exp_q.push_back(32'h2);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL mask_keep: got %h want %h", rd, e);
        end
        bus_write(ADDR_MASK, 32'hF);
        idle(1);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL unmask: got %b want 1", irq_out);
        end
        bus_write(ADDR_CONTROL, 32'h2);
        idle(1);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL gen_drop: got %b want 0", irq_out);
        end
        exp_q.push_back(32'h2);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL gen_keep: got %h want %h", rd, e);
        end
        bus_write(ADDR_CONTROL, 32'h3);
        bus_write(ADDR_PENDING, 32'hF);
        idle(2);
    endtask

    task automatic test_back_to_back;
        irq_src[3] = 1'b1;
        idle(LAT + 2);
        irq_src[3] = 1'b0;
        idle(LAT + 2);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL src3_keep: got %b want 1", irq_out);
        end
        irq_src[3] = 1'b1;
        idle(LAT - 1);
        bus_write(ADDR_PENDING, 32'h8);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL coll_irq: got %b want 1", irq_out);
        end
        exp_q.push_back(32'h8);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL coll_pend: got %h want %h", rd, e);
        end
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL coll_irq2: got %b want 1", irq_out);
        end
        bus_write(ADDR_PENDING, 32'h8);
        idle(1);
    endtask

    task automatic test_rw;
        bus_write(ADDR_MASK, 32'hFFFF_FFFF);
        exp_q.push_back(32'hF);
        bus_read(ADDR_MASK, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL rw_mask: got %h want %h", rd, e);
        end
        bus_write(ADDR_CONTROL, 32'hFFFF_FFFF);
        exp_q.push_back(32'h1F);
        bus_read(ADDR_CONTROL, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL rw_ctrl: got %h want %h", rd, e);
        end
        bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
        exp_q.push_back(32'hE);
        bus_read(ADDR_STATUS, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL rw_status: got %h want %h", rd, e);
        end
        bus_write(ADDR_CONTROL, 32'h1);
        idle(2);
        exp_q.push_back(32'h0);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL rw_pend: got %h want %h", rd, e);
        end
    endtask

    task automatic test_pulse;
        logic ok;
        irq_src = '0;
        idle(LAT + 8);
        bus_write(ADDR_PENDING, 32'hF);
`ifdef DEBUG_IRQ_DEBOUNCE_EN
        ok = 1'b1;
        bus.address = ADDR_STATUS;
        irq_src[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.readdata[1] !== 1'b0) ok = 1'b0;
        end
        irq_src[1] = 1'b0;
        repeat (DEB + LAT) begin
            @(negedge clk);
            if (bus.readdata[1] !== 1'b0) ok = 1'b0;
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL glitch_status: got %b want 1", ok);
        end
        exp_q.push_back(32'h0);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL glitch_pend: got %h want %h", rd, e);
        end
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL glitch_irq: got %b want 0", irq_out);
        end
`else
        ok = 1'b0;
        irq_src[0] = 1'b1;
        idle(3);
        irq_src[0] = 1'b0;
        idle(LAT + 2);
        exp_q.push_back(32'h1);
        bus_read(ADDR_PENDING, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL pulse_pend: got %h want %h", rd, e);
        end
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL pulse_irq: got %b want 1 (ok=%b)", irq_out, ok);
        end
`endif
    endtask

    task automatic test_reset_mid;
        bus_write(ADDR_PENDING, 32'hF);
        irq_src[2] = 1'b1;
        idle(LAT + 2);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst_irq: got %b want 1", irq_out);
        end
        bus.address = ADDR_MASK;
        idle(1);
        reset_n = 1'b0;
        #1;
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL async_irq: got %b want 0", irq_out);
        end
        total++;
        if (bus.readdata !== 32'h0) begin
            bad++;
            $display("FAIL async_rd: got %h want 0", bus.readdata);
        end
        idle(2);
        reset_n = 1'b1;
        idle(2);
        exp_q.push_back(32'h0);
        bus_read(ADDR_MASK, rd);
        e = exp_q.pop_front();
        total++;
        if (rd !== e) begin
            bad++;
            $display("FAIL rst_mask: got %h want %h", rd, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_polarity();
        test_mask_gate();
        test_back_to_back();
        test_rw();
        test_pulse();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
